npu_out_buffer: RTL and testbench
=================================

# npu_out_buffer

Parametrised output buffer for the NPU matrix result path: LANES single-port RAM banks sharing one address, filled row-by-row through a valid/ready write port and drained by an internal sequencer through a valid/ready read stream. Adds per-lane write masking, a programmable drain window with address wrap, and a row-parallel or lane-serial drain mode. It sits between the matrix datapath and the host/readback interface.

## Interface
- LANES, 4, number of banks, one DATA_W word each per row
- DATA_W, 16, lane word width
- DEPTH, 8192, rows per bank
- ADDR_W, $clog2(DEPTH), row address width
- clk  in  1  single clock; all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- wr_valid  in  1  write row offered
- wr_ready  out  1  buffer accepts write (= !drain_busy)
- wr_addr  in  ADDR_W  target row
- wr_data  in  DATA_W x LANES  row data, element i to bank i
- wr_mask  in  LANES  per-lane write enable; 0 leaves that bank's word unchanged
- drain_start  in  1  start request, sampled only in IDLE
- drain_base  in  ADDR_W  first row of drain window
- drain_len  in  ADDR_W+1  rows to drain, 0..DEPTH
- drain_serial  in  1  0 = one row per beat; 1 = one lane word per beat
- drain_busy  out  1  drain in progress
- drain_done  out  1  one-cycle pulse at drain completion
- rd_valid  out  1  output beat valid
- rd_ready  in  1  consumer accepts beat
- rd_data  out  DATA_W x LANES  parallel: full row; serial: word in element 0, others 0
- rd_last  out  1  marks final beat of drain

## Operation
- Reset values: wr_ready 1, drain_busy 0, drain_done 0, rd_valid 0, rd_data 0, rd_last 0; FSM IDLE; counters 0. RAM contents not cleared.
- Write: on wr_valid && wr_ready, banks with wr_mask[i]=1 store wr_data[i] at wr_addr. No write while drain_busy (wr_ready=0).
- FSM states: IDLE, RUN, FLUSH.
  - IDLE -> RUN on drain_start with drain_len != 0; latch base, len, mode.
  - IDLE -> IDLE on drain_start with drain_len == 0: drain_done pulses next cycle, drain_busy never rises, no beats.
  - RUN: issue one row read per cycle while issued_rows < len and skid space (2-entry row FIFO minus in-flight reads) allows. Row address = (base + issued_rows) mod DEPTH.
  - RUN -> FLUSH when all rows issued; FLUSH -> IDLE when FIFO empty and final beat accepted.
- Serial mode: each row emits LANES beats, lane 0 first; row popped after lane LANES-1 accepted.
- rd_last high with the final beat only (row len-1; in serial also lane LANES-1).
- drain_start while busy: ignored.
- Async reset mid-drain: FSM to IDLE, FIFO flushed, rd_valid drops immediately; no drain_done.

## Timing
- RAM read latency 1 cycle (registered address).
- drain_start accepted at edge E0 -> first read address registered at E1 -> rd_valid high after E2 (2 cycles).
- Parallel mode with rd_ready held high: one beat per cycle, len beats in len cycles after first.
- Serial mode with rd_ready high: LANES*len consecutive beats.
- rd_data/rd_valid/rd_last stable while rd_valid && !rd_ready.
- drain_done pulses, and drain_busy falls, in the cycle after the final beat handshake; wr_ready returns in that same cycle.
- Write accepted at edge E is readable by a drain whose reads issue at E+1 or later.

## Structure
- Package npu_out_pkg: lane_word_t (logic [DATA_W-1:0]), drain_state_e {IDLE, RUN, FLUSH}, default LANES/DATA_W/DEPTH constants.
- Sub-module npu_out_bank: one single-port RAM (clk, addr, wdata, we, q), DEPTH x DATA_W, 1-cycle read; instantiated LANES times by generate.
- Top holds FSM, issue/beat counters, 2-entry skid FIFO, lane selector.

## Test plan
- Write rows 0..3 with data row*16+lane, mask 4'hF; drain base 0 len 4 parallel, rd_ready=1 -> 4 beats on consecutive cycles, first 2 cycles after start, rd_last on beat 3, drain_done next cycle.
- Write row 5 all 16'hAAAA, then row 5 with 16'h5555 mask 4'b0101 -> drain returns {AAAA,5555,AAAA,5555} (lane 3..0).
- Serial drain base 8190 len 3, DEPTH 8192 -> 12 beats from rows 8190, 8191, 0, lane order 0..3, rd_last only on 12th.
- Random rd_ready backpressure (50%) on len 64 parallel drain -> every row exactly once, in order, beat held stable while stalled.
- drain_len 0 -> no rd_valid, drain_done pulse one cycle later, wr_ready stays 1; drain_start during busy -> ignored.
- Assert rst_n low mid-drain after 10 beats -> rd_valid, drain_busy 0 immediately, no drain_done; new drain after reset returns correct data.

Source files
------------

// File: rtl/npu_out_pkg.sv
// Shared types and default geometry for the NPU output buffer.
package npu_out_pkg;

  localparam int LANES_DEF  = 4;
  localparam int DATA_W_DEF = 16;
  localparam int DEPTH_DEF  = 8192;

  typedef logic [DATA_W_DEF-1:0] lane_word_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } drain_state_e;

endpackage

// File: rtl/npu_out_buffer_if.sv
// Row write port and drain read stream of the NPU output buffer.
interface npu_out_buffer_if
  import npu_out_pkg::*;
#(
  parameter int LANES  = LANES_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = $clog2(DEPTH_DEF)
);
  logic                         wr_valid;
  logic                         wr_ready;
  logic [ADDR_W-1:0]            wr_addr;
  logic [LANES-1:0][DATA_W-1:0] wr_data;
  logic [LANES-1:0]             wr_mask;
  logic                         rd_valid;
  logic                         rd_ready;
  logic [LANES-1:0][DATA_W-1:0] rd_data;
  logic                         rd_last;

  // Producer of rows / consumer of the drain stream.
  modport master (
    output wr_valid, wr_addr, wr_data, wr_mask, rd_ready,
    input  wr_ready, rd_valid, rd_data, rd_last
  );

  // The buffer itself.
  modport slave (
    input  wr_valid, wr_addr, wr_data, wr_mask, rd_ready,
    output wr_ready, rd_valid, rd_data, rd_last
  );
endinterface

// File: rtl/npu_out_bank.sv
// One lane bank: single-port RAM with registered read (1-cycle latency).
module npu_out_bank #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 8192,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              we,
  output logic [DATA_W-1:0] q
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Write-enabled store plus read-first registered output.
  // NOTE: RAM arrays get no reset; a reset loop would stop the array mapping onto a RAM macro.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    q <= mem[addr];
  end

endmodule

// File: rtl/npu_out_buffer.sv
// NPU output buffer: LANES banks sharing one row address, valid/ready row
// writes, and a sequenced drain with address wrap and parallel/serial beats.
module npu_out_buffer
  import npu_out_pkg::*;
#(
  parameter int LANES  = LANES_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  npu_out_buffer_if.slave   bus,
  input  logic              drain_start,
  input  logic [ADDR_W-1:0] drain_base,
  input  logic [ADDR_W:0]   drain_len,
  input  logic              drain_serial,
  output logic              drain_busy,
  output logic              drain_done
);

  localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int CNT_W  = ADDR_W + 1;

  typedef logic [LANES-1:0][DATA_W-1:0] row_t;

  drain_state_e      state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [CNT_W-1:0]  len_q, len_d;
  logic [CNT_W-1:0]  issued_q, issued_d;
  logic [CNT_W-1:0]  rows_out_q, rows_out_d;
  logic              serial_q, serial_d;
  logic [LANE_W-1:0] lane_q, lane_d;
  logic              inflight_q, inflight_d;
  logic              done_q, done_d;
  row_t              fifo_q [2];
  row_t              fifo_d [2];
  logic              wptr_q, wptr_d, rptr_q, rptr_d;
  logic [1:0]        count_q, count_d;

  row_t              ram_q, head, rd_data_c;
  logic [CNT_W-1:0]  addr_sum;
  logic [ADDR_W-1:0] rd_addr, ram_addr;
  logic              wr_fire, rd_valid_c, beat, last_lane, last_row, pop_row, issue;

  assign drain_busy   = (state_q != IDLE);
  assign drain_done   = done_q;
  assign bus.wr_ready = (state_q == IDLE);
  assign wr_fire      = bus.wr_valid && (state_q == IDLE);

  assign rd_valid_c   = (count_q != 2'd0);
  assign head         = fifo_q[rptr_q];
  assign beat         = rd_valid_c && bus.rd_ready;
  assign last_lane    = !serial_q || (lane_q == LANE_W'(LANES - 1));
  assign last_row     = (rows_out_q == len_q - CNT_W'(1));
  assign pop_row      = beat && last_lane;

  assign bus.rd_valid = rd_valid_c;
  assign bus.rd_last  = rd_valid_c && last_row && last_lane;
  assign bus.rd_data  = rd_data_c;

  // Drain window address with wrap at DEPTH (DEPTH need not be a power of two).
  assign addr_sum = CNT_W'(base_q) + issued_q;
  assign rd_addr  = (addr_sum >= CNT_W'(DEPTH)) ? ADDR_W'(addr_sum - CNT_W'(DEPTH))
                                                : ADDR_W'(addr_sum);
  assign ram_addr = (state_q == IDLE) ? bus.wr_addr : rd_addr;

  // Issue a row read only if it is guaranteed a FIFO slot when its data lands.
  assign issue = (state_q == RUN) && (issued_q < len_q) &&
                 ((int'(count_q) + int'(inflight_q) - int'(pop_row)) < 2);

  for (genvar i = 0; i < LANES; i++) begin : g_bank
    npu_out_bank #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_bank (
      .clk   (clk),
      .addr  (ram_addr),
      .wdata (bus.wr_data[i]),
      .we    (wr_fire && bus.wr_mask[i]),
      .q     (ram_q[i])
    );
  end

  // Output beat: full head row, or the selected lane word in element 0.
  always_comb begin
    rd_data_c = '0;
    if (rd_valid_c) begin
      if (serial_q) rd_data_c[0] = head[lane_q];
      else          rd_data_c    = head;
    end
  end

  // Next-state: FSM, counters, skid FIFO bookkeeping.
  // NOTE: every always_comb target gets a default first so no path infers a latch.
  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    len_d      = len_q;
    serial_d   = serial_q;
    issued_d   = issued_q;
    rows_out_d = rows_out_q;
    lane_d     = lane_q;
    inflight_d = issue;
    done_d     = 1'b0;
    fifo_d     = fifo_q;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    count_d    = count_q + {1'b0, inflight_q} - {1'b0, pop_row};

    if (inflight_q) begin
      fifo_d[wptr_q] = ram_q;
      wptr_d         = ~wptr_q;
    end
    if (pop_row) begin
      rptr_d     = ~rptr_q;
      rows_out_d = rows_out_q + CNT_W'(1);
    end
    if (beat)  lane_d   = last_lane ? '0 : lane_q + LANE_W'(1);
    if (issue) issued_d = issued_q + CNT_W'(1);

    case (state_q)
      IDLE: begin
        if (drain_start) begin
          if (drain_len == '0) begin
            done_d = 1'b1;
          end else begin
            state_d    = RUN;
            base_d     = drain_base;
            len_d      = drain_len;
            serial_d   = drain_serial;
            issued_d   = '0;
            rows_out_d = '0;
            lane_d     = '0;
          end
        end
      end
      RUN: begin
        if (issue && (issued_q + CNT_W'(1) == len_q)) state_d = FLUSH;
      end
      FLUSH: begin
        if (pop_row && last_row) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control state registers.
  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      base_q     <= '0;
      len_q      <= '0;
      serial_q   <= 1'b0;
      issued_q   <= '0;
      rows_out_q <= '0;
      lane_q     <= '0;
      inflight_q <= 1'b0;
      done_q     <= 1'b0;
      wptr_q     <= 1'b0;
      rptr_q     <= 1'b0;
      count_q    <= 2'd0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      len_q      <= len_d;
      serial_q   <= serial_d;
      issued_q   <= issued_d;
      rows_out_q <= rows_out_d;
      lane_q     <= lane_d;
      inflight_q <= inflight_d;
      done_q     <= done_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
    end
  end

  // Skid FIFO payload; only the occupancy count qualifies it, so it needs no reset.
  always_ff @(posedge clk) begin
    fifo_q <= fifo_d;
  end

endmodule

// File: tb/tb_npu_out_buffer.sv
// Directed bench for npu_out_buffer with a shadow memory and beat scoreboard.
module tb_npu_out_buffer;
  import npu_out_pkg::*;

  localparam int LANES  = 4;
  localparam int DATA_W = 16;
  localparam int DEPTH  = 8192;
  localparam int ADDR_W = $clog2(DEPTH);

  typedef logic [LANES*DATA_W-1:0] row_t;
  typedef struct packed {
    row_t data;
    logic last;
  } beat_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              drain_start = 1'b0;
  logic [ADDR_W-1:0] drain_base = '0;
  logic [ADDR_W:0]   drain_len = '0;
  logic              drain_serial = 1'b0;
  logic              drain_busy, drain_done;

  npu_out_buffer_if #(.LANES(LANES), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  npu_out_buffer #(.LANES(LANES), .DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus),
    .drain_start  (drain_start),
    .drain_base   (drain_base),
    .drain_len    (drain_len),
    .drain_serial (drain_serial),
    .drain_busy   (drain_busy),
    .drain_done   (drain_done)
  );

  initial forever #5 clk = ~clk;

  row_t  model [DEPTH];
  beat_t sb [$];
  int    n_checks = 0;
  int    n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Entered and left at posedge+1.
  task automatic write_row(input int addr, input row_t data, input logic [LANES-1:0] mask);
    bus.wr_valid = 1'b1;
    bus.wr_addr  = addr[ADDR_W-1:0];
    bus.wr_data  = data;
    bus.wr_mask  = mask;
    @(negedge clk);
    check("wr_ready", bus.wr_ready, 1'b1);
    @(posedge clk) #1;
    bus.wr_valid = 1'b0;
    for (int l = 0; l < LANES; l++)
      if (mask[l]) model[addr][l*DATA_W +: DATA_W] = data[l*DATA_W +: DATA_W];
  endtask

  // Entered and left at posedge+1. abort_beats >= 0 pulls reset after that many beats.
  task automatic run_drain(input string tag, input int base, input int len, input bit serial,
                           input int ready_pct, input int poke_cycle, input int abort_beats);
    int         cyc, first_cyc, last_cyc, beats, n_exp, addr;
    bit         done_seen, stalled, aborted;
    beat_t      b;
    row_t       row;
    lane_word_t w;

    for (int r = 0; r < len; r++) begin
      addr = (base + r) % DEPTH;
      row  = model[addr];
      if (!serial) begin
        b.data = row; b.last = (r == len - 1); sb.push_back(b);
      end else begin
        for (int l = 0; l < LANES; l++) begin
          w      = row[l*DATA_W +: DATA_W];
          b.data = row_t'(w);
          b.last = (r == len - 1) && (l == LANES - 1);
          sb.push_back(b);
        end
      end
    end
    n_exp = serial ? len * LANES : len;

    drain_base   = base[ADDR_W-1:0];
    drain_len    = len[ADDR_W:0];
    drain_serial = serial;
    drain_start  = 1'b1;
    @(posedge clk) #1;
    drain_start = 1'b0;

    cyc = 0; first_cyc = -1; last_cyc = -1; beats = 0;
    done_seen = 0; stalled = 0; aborted = 0;
    while (!done_seen && cyc < 3000) begin
      bus.rd_ready = ($urandom_range(99) < ready_pct);
      drain_start  = (cyc == poke_cycle);
      @(negedge clk);
      if (cyc == 0) begin
        check({tag, " busy"}, drain_busy, 1'b1);
        check({tag, " wr_ready low"}, bus.wr_ready, 1'b0);
      end
      if (stalled) check({tag, " held valid"}, bus.rd_valid, 1'b1);
      stalled = 0;
      if (bus.rd_valid) begin
        if (first_cyc < 0) first_cyc = cyc;
        if (sb.size() == 0) begin
          check({tag, " extra beat"}, bus.rd_valid, 1'b0);
        end else begin
          b = sb[0];
          check({tag, " data"}, bus.rd_data, b.data);
          check({tag, " last"}, bus.rd_last, b.last);
          if (bus.rd_ready) begin
            void'(sb.pop_front());
            beats++;
            last_cyc = cyc;
          end else begin
            stalled = 1;
          end
        end
      end
      if (drain_done) begin
        done_seen = 1;
        check({tag, " done timing"}, 64'(cyc), 64'(last_cyc + 1));
        check({tag, " busy fall"}, drain_busy, 1'b0);
        check({tag, " wr_ready back"}, bus.wr_ready, 1'b1);
        check({tag, " beats left"}, 64'(sb.size()), 64'd0);
      end
      if (abort_beats >= 0 && beats == abort_beats) begin
        #2 rst_n = 1'b0;
        #1;
        check({tag, " rst rd_valid"}, bus.rd_valid, 1'b0);
        check({tag, " rst busy"}, drain_busy, 1'b0);
        check({tag, " rst done"}, drain_done, 1'b0);
        repeat (2) begin
          @(negedge clk);
          check({tag, " rst no done"}, drain_done, 1'b0);
        end
        rst_n = 1'b1;
        sb.delete();
        aborted = 1;
        bus.rd_ready = 1'b0;
        drain_start  = 1'b0;
        @(posedge clk) #1;
        break;
      end
      @(posedge clk) #1;
      cyc++;
    end
    drain_start  = 1'b0;
    bus.rd_ready = 1'b0;

    check({tag, " first beat latency"}, 64'(first_cyc), 64'd2);
    if (!aborted) begin
      if (!done_seen) check({tag, " drain_done timeout"}, drain_done, 1'b1);
      check({tag, " beat count"}, 64'(beats), 64'(n_exp));
      if (ready_pct >= 100)
        check({tag, " back-to-back"}, 64'(last_cyc - first_cyc), 64'(n_exp - 1));
      @(negedge clk);
      check({tag, " done one cycle"}, drain_done, 1'b0);
      check({tag, " idle rd_valid"}, bus.rd_valid, 1'b0);
      check({tag, " idle busy"}, drain_busy, 1'b0);
      @(posedge clk) #1;
    end
  endtask

  initial begin
    row_t r;
    bus.wr_valid = 1'b0;
    bus.wr_addr  = '0;
    bus.wr_data  = '0;
    bus.wr_mask  = '0;
    bus.rd_ready = 1'b0;

    // Reset state.
    #12;
    check("reset wr_ready", bus.wr_ready, 1'b1);
    check("reset busy", drain_busy, 1'b0);
    check("reset done", drain_done, 1'b0);
    check("reset rd_valid", bus.rd_valid, 1'b0);
    check("reset rd_data", bus.rd_data, 64'd0);
    check("reset rd_last", bus.rd_last, 1'b0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk) #1;

    // Rows 0..3 = row*16+lane, parallel drain, plus an ignored start while busy.
    for (int row = 0; row < 4; row++) begin
      for (int l = 0; l < LANES; l++) r[l*DATA_W +: DATA_W] = DATA_W'(row * 16 + l);
      write_row(row, r, 4'hF);
    end
    run_drain("par4", 0, 4, 1'b0, 100, 3, -1);

    // Masked overwrite of row 5.
    write_row(5, {LANES{16'hAAAA}}, 4'hF);
    write_row(5, {LANES{16'h5555}}, 4'b0101);
    run_drain("mask", 5, 1, 1'b0, 100, -1, -1);

    // Serial drain across the top-of-memory wrap.
    write_row(8190, 64'h1111_2222_3333_4444, 4'hF);
    write_row(8191, 64'h9999_8888_7777_6666, 4'hF);
    run_drain("serial wrap", 8190, 3, 1'b1, 100, -1, -1);

    // 64 random rows under 50% backpressure.
    for (int row = 100; row < 164; row++) write_row(row, {$urandom, $urandom}, 4'hF);
    run_drain("backpressure", 100, 64, 1'b0, 50, -1, -1);

    // Zero-length drain: done pulse only.
    drain_len   = '0;
    drain_base  = 13'd7;
    drain_start = 1'b1;
    @(posedge clk) #1;
    drain_start = 1'b0;
    @(negedge clk);
    check("len0 done", drain_done, 1'b1);
    check("len0 busy", drain_busy, 1'b0);
    check("len0 wr_ready", bus.wr_ready, 1'b1);
    check("len0 rd_valid", bus.rd_valid, 1'b0);
    @(negedge clk);
    check("len0 done pulse", drain_done, 1'b0);
    check("len0 no beat", bus.rd_valid, 1'b0);
    @(posedge clk) #1;

    // Reset mid-drain, then a fresh drain over the retained contents.
    run_drain("abort", 100, 64, 1'b0, 100, -1, 10);
    run_drain("post reset", 100, 8, 1'b0, 100, -1, -1);
    run_drain("post reset serial", 0, 2, 1'b1, 100, -1, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
